// File: rtl/div_arbiter_if.sv
// Handshake bundle between div_arbiter, its requesters and the shared divider.
// slave = arbiter side, master = requester/divider side.
`timescale 1ns/1ps
interface div_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
);
    logic [NREQ-1:0]             i_req;
    logic [NREQ-1:0][WIDTH-1:0] i_num;
    logic [NREQ-1:0][WIDTH-1:0] i_denom;
    logic [NREQ-1:0]             o_ack;
    logic [WIDTH-1:0]            o_result;
    logic                        o_dz;
    logic                        o_err;
    logic                        o_busy;
    logic [WIDTH-1:0]            o_div_num;
    logic [WIDTH-1:0]            o_div_denom;
    logic                        o_div_start;
    logic [WIDTH-1:0]            i_div_result;
    logic                        i_div_done;
    logic                        i_div_valid;

    modport slave (
        input  i_req, i_num, i_denom,
        input  i_div_result, i_div_done, i_div_valid,
        output o_ack, o_result, o_dz, o_err, o_busy,
        output o_div_num, o_div_denom, o_div_start
    );

    modport master (
        output i_req, i_num, i_denom,
        output i_div_result, i_div_done, i_div_valid,
        input  o_ack, o_result, o_dz, o_err, o_busy,
        input  o_div_num, o_div_denom, o_div_start
    );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin scheduler sharing one fixed-point divider among NREQ requesters.
// Zero denominators are answered with a saturated quotient without the divider.
`timescale 1ns/1ps
module div_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int QBITS = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    div_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [NREQ-1:0]  ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    // QBITS only configures the divider; reject a setting it cannot honour.
    if (QBITS >= WIDTH || NREQ < 2) begin : g_param_check
        $error("div_arbiter: need NREQ>=2 and QBITS<WIDTH");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DELAY,
        S_WAIT,
        S_RESPOND
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    gnt_q, gnt_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [WIDTH-1:0] denom_q, denom_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             dz_q, dz_d;
    logic             err_q, err_d;

    logic             pick_vld;
    logic [PW-1:0]    pick_idx;
    logic [PW:0]      cand_sum;
    logic [PW-1:0]    cand;

    // Round-robin search: first requester at or after ptr, wrapping mod NREQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand_sum = '0;
        cand     = '0;
        for (int j = 0; j < NREQ; j++) begin
            cand_sum = {1'b0, ptr_q} + (PW+1)'(j);
            if (cand_sum >= (PW+1)'(NREQ)) begin
                cand_sum = cand_sum - (PW+1)'(NREQ);
            end
            cand = cand_sum[PW-1:0];
            if (!pick_vld && bus.i_req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Next-state logic for the grant/issue/wait/respond sequence.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        num_d    = num_q;
        denom_d  = denom_q;
        result_d = result_q;
        dz_d     = dz_q;
        err_d    = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    gnt_d   = pick_idx;
                    num_d   = bus.i_num[pick_idx];
                    denom_d = bus.i_denom[pick_idx];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (denom_q == '0) begin
                    result_d = num_q[WIDTH-1] ? SAT_NEG : SAT_POS;
                    dz_d     = 1'b1;
                    err_d    = 1'b0;
                    state_d  = S_RESPOND;
                end else begin
                    state_d = S_DELAY;
                end
            end
            S_DELAY: begin
                // Divider's done is not trustworthy in the cycle after start.
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.i_div_done) begin
                    result_d = bus.i_div_result;
                    err_d    = ~bus.i_div_valid;
                    dz_d     = 1'b0;
                    state_d  = S_RESPOND;
                end
            end
            S_RESPOND: begin
                ptr_d   = (gnt_q == PW'(NREQ-1)) ? '0 : gnt_q + PW'(1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight divide.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            num_q    <= '0;
            denom_q  <= '0;
            result_q <= '0;
            dz_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            num_q    <= num_d;
            denom_q  <= denom_d;
            result_q <= result_d;
            dz_q     <= dz_d;
            err_q    <= err_d;
        end
    end

    assign bus.o_ack       = (state_q == S_RESPOND) ? (ONE_HOT0 << gnt_q) : '0;
    assign bus.o_result    = result_q;
    assign bus.o_dz        = (state_q == S_RESPOND) && dz_q;
    assign bus.o_err       = (state_q == S_RESPOND) && err_q;
    assign bus.o_busy      = (state_q != S_IDLE);
    assign bus.o_div_num   = num_q;
    assign bus.o_div_denom = denom_q;
    assign bus.o_div_start = (state_q == S_ISSUE) && (denom_q != '0);

endmodule
